// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath plus on-the-fly key
// expansion, sequenced by a small IDLE/ROUND/DONE controller.
//
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   ROUND | one AES round per cycle, rnd = 1..NR
//   DONE  | ciphertext presented on out_data until out_ready
module aes128_iter_ctrl #(
   parameter int NR    = 10,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_data,
   input  logic [127:0]       in_key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       out_data,
   output logic               busy,
   output logic [CNT_W-1:0]   round_idx
);

   if (NR != 10 || (2 ** CNT_W) <= NR) begin : g_cfg_err
      $error("aes128_iter_ctrl: only NR=10 with 2**CNT_W > NR is supported");
   end

   localparam logic [CNT_W-1:0] NR_C  = CNT_W'(NR);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t             fsm, fsm_nxt;
   logic [127:0]       st, rk;
   logic [CNT_W-1:0]   rnd;
   logic               accept;
   logic [127:0]       sb, sr, mc, nk;
   logic [31:0]        tw;

   // Byte 0 sits in the top byte, so entry x is found counting down from the MSB.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
      case (int'(r))
         1:       return 8'h01;
         2:       return 8'h02;
         3:       return 8'h04;
         4:       return 8'h08;
         5:       return 8'h10;
         6:       return 8'h20;
         7:       return 8'h40;
         8:       return 8'h80;
         9:       return 8'h1b;
         10:      return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   always_comb begin
      tw = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^
           {rcon(rnd), 24'h0};
      nk[127:96] = rk[127:96] ^ tw;
      nk[95:64]  = rk[95:64]  ^ nk[127:96];
      nk[63:32]  = rk[63:32]  ^ nk[95:64];
      nk[31:0]   = rk[31:0]   ^ nk[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt   = fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               fsm_nxt = ROUND;
            end
         end
         ROUND: begin
            busy = 1'b1;
            if (rnd == NR_C) fsm_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               accept  = in_valid;
               fsm_nxt = in_valid ? ROUND : IDLE;
            end
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   // The last round skips MixColumns; rnd returns to 0 so round_idx reads 0 in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st  <= '0;
         rk  <= '0;
         rnd <= '0;
      end else if (accept) begin
         st  <= in_data ^ in_key;
         rk  <= in_key;
         rnd <= ONE_C;
      end else if (fsm == ROUND) begin
         st  <= ((rnd == NR_C) ? sr : mc) ^ nk;
         rk  <= nk;
         rnd <= (rnd == NR_C) ? '0 : rnd + ONE_C;
      end
   end

   assign round_idx = (fsm == ROUND) ? rnd : '0;
   assign out_data  = (fsm == DONE) ? st : '0;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl: FIPS-197 vectors, flow control,
// reset mid-block, and random blocks against a byte-level AES model.
module tb_aes128_iter_ctrl;
   localparam int CNT_W = 4;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [127:0]       in_data = '0;
   logic [127:0]       in_key = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [127:0]       out_data;
   logic               busy;
   logic [CNT_W-1:0]   round_idx;

   int                 total = 0;
   int                 bad = 0;
   int                 n;
   int                 stale;
   logic [7:0]         sbm [256];
   logic [7:0]         inv;
   logic [127:0]       rk1_seen = '0;
   logic [127:0]       pt, key;

   always #5 clk = ~clk;

   aes128_iter_ctrl #(.NR(10), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .round_idx(round_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [15:0] d;
      d = {b, b};
      return d[15-k -: 8];
   endfunction

   // FIPS-197 word-oriented key expansion, returns round key n.
   function automatic logic [127:0] round_key(input logic [127:0] k, input int rn);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]], sbm[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*rn], w[4*rn+1], w[4*rn+2], w[4*rn+3]};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] rkv, res;
      rkv = round_key(k, 0);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = p[127-8*(4*c+r) -: 8] ^ rkv[127-8*(4*c+r) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r][c] = sbm[s[r][(c+r)%4]];
         rkv = round_key(k, rd);
         for (int c = 0; c < 4; c++) begin
            if (rd < 10) begin
               s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
               s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] ^= rkv[127-8*(4*c+r) -: 8];
         end
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp,
                           input int stall, input bit scramble, input bit trace_rk, input string tag);
      int m;
      chk1({tag, ":idle_ready"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      in_data   = p;
      in_key    = k;
      out_ready = (stall == 0);
      tick();
      in_valid = 1'b0;
      m = 0;
      while (!out_valid && m < 40) begin
         chkn({tag, ":round_idx"}, int'(round_idx), m + 1);
         chk1({tag, ":busy"}, busy, 1'b1);
         chk1({tag, ":ready_in_round"}, in_ready, 1'b0);
         if (trace_rk) chk128({tag, ":rk"}, dut.rk, round_key(k, m));
         if (m == 1) rk1_seen = dut.rk;
         if (scramble) begin
            in_data = rnd128();
            in_key  = rnd128();
         end
         tick();
         m++;
      end
      chkn({tag, ":latency"}, m, 10);
      chk128({tag, ":out_data"}, out_data, exp);
      chk1({tag, ":busy_done"}, busy, 1'b0);
      chkn({tag, ":round_idx_done"}, int'(round_idx), 0);
      chk1({tag, ":ready_done"}, in_ready, stall == 0);
      if (trace_rk) chk128({tag, ":rk10"}, dut.rk, round_key(k, 10));
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_data  = rnd128();
         in_key   = rnd128();
         tick();
         chk1({tag, ":hold_valid"}, out_valid, 1'b1);
         chk128({tag, ":hold_data"}, out_data, exp);
         chk1({tag, ":hold_ready"}, in_ready, 1'b0);
         chk1({tag, ":hold_busy"}, busy, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk1({tag, ":ready_release"}, in_ready, 1'b1);
      tick();
      chk1({tag, ":single_xfer"}, out_valid, 1'b0);
      chk1({tag, ":no_accept"}, busy, 1'b0);
   endtask

   initial begin
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      #12;
      chk1("reset:in_ready", in_ready, 1'b1);
      chk1("reset:out_valid", out_valid, 1'b0);
      chk1("reset:busy", busy, 1'b0);
      chkn("reset:round_idx", int'(round_idx), 0);
      chk128("reset:out_data", out_data, '0);
      rst = 1'b0;
      tick();

      do_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, 1'b0, "c1");

      do_block(B_PT, B_KEY, B_CT, 0, 1'b0, 1'b1, "appb");
      chk128("appb:rk1_lit", rk1_seen, 128'ha0fafe1788542cb123a339392a6c7605);
      chk128("appb:rk10_lit", dut.rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      do_block(B_PT, B_KEY, B_CT, 5, 1'b0, 1'b0, "backpressure");

      do_block(C1_PT, C1_KEY, C1_CT, 0, 1'b1, 1'b0, "isolation");

      in_valid  = 1'b1;
      in_data   = C1_PT;
      in_key    = C1_KEY;
      out_ready = 1'b1;
      tick();
      in_data = B_PT;
      in_key  = B_KEY;
      n = 0;
      while (!out_valid && n < 40) begin
         chk1("b2b:ready_in_round", in_ready, 1'b0);
         tick();
         n++;
      end
      chkn("b2b:latency1", n, 10);
      chk128("b2b:c1_data", out_data, C1_CT);
      chk1("b2b:ready_at_done", in_ready, 1'b1);
      tick();
      chk1("b2b:valid_drop", out_valid, 1'b0);
      chk1("b2b:second_accept", busy, 1'b1);
      chkn("b2b:round1", int'(round_idx), 1);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chkn("b2b:gap", n, 11);
      chk128("b2b:b_data", out_data, B_CT);
      tick();
      chk1("b2b:end_valid", out_valid, 1'b0);

      in_valid = 1'b1;
      in_data  = C1_PT;
      in_key   = C1_KEY;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (int'(round_idx) != 5 && n < 20) begin
         tick();
         n++;
      end
      chkn("rst:reach5", int'(round_idx), 5);
      #2 rst = 1'b1;
      #1;
      chk1("rst:in_ready", in_ready, 1'b1);
      chk1("rst:busy", busy, 1'b0);
      chk1("rst:out_valid", out_valid, 1'b0);
      chkn("rst:round_idx", int'(round_idx), 0);
      chk128("rst:out_data", out_data, '0);
      #2 rst = 1'b0;
      stale = 0;
      repeat (15) begin
         tick();
         if (out_valid) stale++;
      end
      chkn("rst:stale_valid", stale, 0);
      do_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, 1'b0, "after_rst");

      for (int k = 0; k < 8; k++) begin
         pt  = rnd128();
         key = rnd128();
         do_block(pt, key, aes_ref(pt, key), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
